// File: rtl/dmi_arbiter.sv
// DMI arbiter: shares the Debug Module's single DMI port between the JTAG DTM
// (port 0) and a secondary debug transport (port 1). One transaction in
// flight, round-robin grant, response routed back to its issuer, and a
// watchdog that synthesises a DTM_ERR response if the DM never answers.
module dmi_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [40:0] req0_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    output logic [33:0] resp0_o,
    output logic        resp0_valid_o,
    input  logic        resp0_ready_i,
    input  logic [40:0] req1_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    output logic [33:0] resp1_o,
    output logic        resp1_valid_o,
    input  logic        resp1_ready_i,
    output logic [40:0] dm_req_o,
    output logic        dm_req_valid_o,
    input  logic        dm_req_ready_i,
    input  logic [33:0] dm_resp_i,
    input  logic        dm_resp_valid_i,
    output logic        dm_resp_ready_o,
    output logic [1:0]  owner_o,
    output logic        timeout_o
);

    localparam logic [1:0]       LP_DTM_ERR  = 2'h2;
    localparam logic             LP_WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_RETURN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_owner;
    logic               r_last;
    logic [40:0]        r_req;
    logic [33:0]        r_resp;
    logic [CNT_W-1:0]   r_cnt;

    logic w_block;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;
    logic w_take_resp;
    logic w_count;
    logic w_done;

    // Reset and clear both suppress every handshake in the cycle they are seen.
    assign w_block  = rst_i | clear_i;
    assign dm_req_o = r_req;
    assign owner_o  = r_owner;
    assign resp0_o  = (r_state == ST_RETURN && r_owner[0]) ? r_resp : '0;
    assign resp1_o  = (r_state == ST_RETURN && r_owner[1]) ? r_resp : '0;

    // Next-state logic and all handshake outputs, decoded from the current state.
    always_comb begin
        w_state_nxt     = r_state;
        req0_ready_o    = 1'b0;
        req1_ready_o    = 1'b0;
        dm_req_valid_o  = 1'b0;
        dm_resp_ready_o = 1'b0;
        resp0_valid_o   = 1'b0;
        resp1_valid_o   = 1'b0;
        timeout_o       = 1'b0;
        w_grant0        = 1'b0;
        w_grant1        = 1'b0;
        w_accept        = 1'b0;
        w_take_resp     = 1'b0;
        w_count         = 1'b0;
        w_done          = 1'b0;
        if (!w_block) begin
            case (r_state)
                ST_IDLE: begin
                    // On a tie the port that was not served last wins.
                    w_grant1     = req1_valid_i & (~req0_valid_i | ~r_last);
                    w_grant0     = req0_valid_i & ~w_grant1;
                    req0_ready_o = w_grant0;
                    req1_ready_o = w_grant1;
                    if (w_grant0 || w_grant1) begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    dm_req_valid_o = 1'b1;
                    if (dm_req_ready_i) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    dm_resp_ready_o = 1'b1;
                    if (dm_resp_valid_i) begin
                        w_take_resp = 1'b1;
                        w_state_nxt = ST_RETURN;
                    end else if (LP_WD_EN && r_cnt == LP_CNT_LAST) begin
                        timeout_o   = 1'b1;
                        w_state_nxt = ST_RETURN;
                    end else begin
                        w_count = 1'b1;
                    end
                end
                ST_RETURN: begin
                    resp0_valid_o = r_owner[0];
                    resp1_valid_o = r_owner[1];
                    if ((r_owner[0] && resp0_ready_i) || (r_owner[1] && resp1_ready_i)) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register; reset and clear both abort to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transaction registers: owner, round-robin pointer, latched request/response, watchdog.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner <= 2'b00;
            r_last  <= 1'b1;
            r_req   <= '0;
            r_resp  <= '0;
            r_cnt   <= '0;
        end else if (clear_i) begin
            r_owner <= 2'b00;
            r_req   <= '0;
            r_resp  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_req   <= w_grant1 ? req1_i : req0_i;
                r_owner <= {w_grant1, w_grant0};
                r_last  <= w_grant1;
            end
            if (w_accept) begin
                r_cnt <= '0;
            end
            if (w_count) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_take_resp) begin
                r_resp <= dm_resp_i;
            end else if (timeout_o) begin
                r_resp <= {32'hDEADBEEF, LP_DTM_ERR};
            end
            if (w_done) begin
                r_owner <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: directed scenarios followed by randomized traffic,
// all cross-checked every cycle against a transaction-level model.
module tb_dmi_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst, clear;
    logic [40:0] req0, req1, dm_req;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [33:0] resp0, resp1, dm_resp;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic        dm_req_valid, dm_req_ready, dm_resp_valid, dm_resp_ready;
    logic [1:0]  owner;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the arbiter
    bit          m_busy, m_sent, m_have;
    int          m_port, m_last, m_waited;
    logic [40:0] m_req;
    logic [33:0] m_resp;

    dmi_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .req0_i(req0), .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .resp0_o(resp0), .resp0_valid_o(resp0_valid), .resp0_ready_i(resp0_ready),
        .req1_i(req1), .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .resp1_o(resp1), .resp1_valid_o(resp1_valid), .resp1_ready_i(resp1_ready),
        .dm_req_o(dm_req), .dm_req_valid_o(dm_req_valid), .dm_req_ready_i(dm_req_ready),
        .dm_resp_i(dm_resp), .dm_resp_valid_i(dm_resp_valid), .dm_resp_ready_o(dm_resp_ready),
        .owner_o(owner), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; clear = 0;
        req0 = '0; req1 = '0; req0_valid = 0; req1_valid = 0;
        resp0_ready = 0; resp1_ready = 0;
        dm_req_ready = 0; dm_resp = '0; dm_resp_valid = 0;
    endtask

    // Let combinational outputs settle after the inputs were driven at negedge.
    task automatic look();
        #1;
    endtask

    // Compare all outputs with the model, advance the model across the coming edge.
    task automatic finish();
        int   win;
        bit   blk, waiting, fire;
        win     = -1;
        blk     = rst || clear;
        if (!blk && !m_busy) begin
            if (req0_valid && req1_valid) win = (m_last == 0) ? 1 : 0;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        waiting = m_busy && m_sent && !m_have;
        fire    = !blk && waiting && !dm_resp_valid && (m_waited == TO - 1);

        chk("req0_ready", req0_ready, win == 0);
        chk("req1_ready", req1_ready, win == 1);
        chk("dm_req", dm_req, m_req);
        chk("dm_req_valid", dm_req_valid, !blk && m_busy && !m_sent);
        chk("dm_resp_ready", dm_resp_ready, !blk && waiting);
        chk("timeout", timeout, fire);
        chk("resp0_valid", resp0_valid, !blk && m_busy && m_have && m_port == 0);
        chk("resp1_valid", resp1_valid, !blk && m_busy && m_have && m_port == 1);
        chk("resp0", resp0, (m_busy && m_have && m_port == 0) ? m_resp : 34'h0);
        chk("resp1", resp1, (m_busy && m_have && m_port == 1) ? m_resp : 34'h0);
        chk("owner", owner, m_busy ? ((m_port == 0) ? 2'b01 : 2'b10) : 2'b00);

        if (rst || clear) begin
            m_busy = 0; m_sent = 0; m_have = 0; m_waited = 0;
            m_req = '0; m_resp = '0;
            if (rst) m_last = 1;
        end else if (win >= 0) begin
            m_busy = 1; m_sent = 0; m_have = 0;
            m_port = win; m_last = win;
            m_req  = (win == 1) ? req1 : req0;
        end else if (m_busy && !m_sent) begin
            if (dm_req_ready) begin
                m_sent = 1; m_waited = 0;
            end
        end else if (waiting) begin
            if (dm_resp_valid) begin
                m_have = 1; m_resp = dm_resp;
            end else if (m_waited == TO - 1) begin
                m_have = 1; m_resp = {32'hDEADBEEF, 2'h2};
            end else begin
                m_waited++;
            end
        end else if (m_busy && m_have) begin
            if ((m_port == 0) ? resp0_ready : resp1_ready) m_busy = 0;
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        look();
        finish();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int          n;
        int          got_port [4];
        logic [33:0] got_data [4];
        logic [63:0] r;

        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        m_busy = 0; m_sent = 0; m_have = 0; m_waited = 0; m_port = 0;
        m_last = 1; m_req = '0; m_resp = '0;
        cycle();
        rst = 0;

        // Reset state
        look();
        chk("rst_owner", owner, 2'b00);
        chk("rst_dm_req", dm_req, 41'h0);
        chk("rst_dm_req_valid", dm_req_valid, 1'b0);
        chk("rst_resp0", resp0, 34'h0);
        finish();

        // Both ports held valid: grants alternate 0,1,0,1
        req0 = {7'h20, 2'b01, 32'h0}; req1 = {7'h31, 2'b01, 32'h0};
        req0_valid = 1; req1_valid = 1;
        resp0_ready = 1; resp1_ready = 1;
        dm_req_ready = 1; dm_resp_valid = 1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            dm_resp = {32'hA000_0000 | {25'b0, dm_req[40:34]}, 2'b00};
            look();
            if (resp0_valid || resp1_valid) begin
                got_port[n] = resp1_valid ? 1 : 0;
                got_data[n] = resp1_valid ? resp1 : resp0;
                n++;
            end
            finish();
        end
        chk("rr_count", n, 4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_port", got_port[k], k % 2);
            chk("rr_data", got_data[k], (k % 2 == 1) ? {32'hA000_0031, 2'b00} : {32'hA000_0020, 2'b00});
        end
        idle_inputs();
        cycle();

        // Single port-0 read, DM answers after 3 cycles
        req0 = {7'h11, 2'b01, 32'h0}; req0_valid = 1;
        look(); chk("t1_grant", req0_ready, 1'b1); finish();
        req0_valid = 0; dm_req_ready = 1;
        look();
        chk("t1_dm_req", dm_req, {7'h11, 2'b01, 32'h0});
        chk("t1_owner", owner, 2'b01);
        finish();
        dm_req_ready = 0;
        cycle(); cycle();
        dm_resp_valid = 1; dm_resp = {32'h0000_0A5A, 2'b00};
        cycle();
        dm_resp_valid = 0; resp0_ready = 1;
        look();
        chk("t1_resp0", resp0, {32'h0000_0A5A, 2'b00});
        chk("t1_resp1_valid", resp1_valid, 1'b0);
        finish();
        resp0_ready = 0;
        look(); chk("t1_owner_idle", owner, 2'b00); finish();

        // DM stalls the request for 5 cycles
        req1 = {7'h05, 2'b10, 32'h1234_5678}; req1_valid = 1;
        cycle();
        req1_valid = 0; req0_valid = 1; req0 = {7'h7F, 2'b01, 32'h0};
        for (int i = 0; i < 5; i++) begin
            look();
            chk("t3_hold_valid", dm_req_valid, 1'b1);
            chk("t3_hold_req", dm_req, {7'h05, 2'b10, 32'h1234_5678});
            chk("t3_no_grant", req0_ready, 1'b0);
            finish();
        end
        req0_valid = 0; dm_req_ready = 1;
        cycle();
        dm_req_ready = 0; dm_resp_valid = 1; dm_resp = {32'h1, 2'b00};
        cycle();
        dm_resp_valid = 0; resp1_ready = 1;
        look(); chk("t3_resp1_valid", resp1_valid, 1'b1); finish();
        idle_inputs();

        // Watchdog fires 8 cycles after acceptance
        req0 = {7'h22, 2'b01, 32'h0}; req0_valid = 1;
        cycle();
        req0_valid = 0; dm_req_ready = 1;
        cycle();
        dm_req_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            look(); chk("t4_timeout", timeout, i == 8); finish();
        end
        resp0_ready = 1;
        look();
        chk("t4_err_resp", resp0, {32'hDEADBEEF, 2'h2});
        chk("t4_err_valid", resp0_valid, 1'b1);
        finish();
        idle_inputs();

        // Response in the same cycle the watchdog would fire
        req0_valid = 1;
        cycle();
        req0_valid = 0; dm_req_ready = 1;
        cycle();
        dm_req_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) begin
                dm_resp_valid = 1; dm_resp = {32'h0BAD_F00D, 2'b00};
            end
            look(); chk("t5_no_timeout", timeout, 1'b0); finish();
        end
        dm_resp_valid = 0; resp0_ready = 1;
        look(); chk("t5_real_resp", resp0, {32'h0BAD_F00D, 2'b00}); finish();
        idle_inputs();

        // Clear during WAIT_RESP, then a port-1 request
        req0_valid = 1;
        cycle();
        req0_valid = 0; dm_req_ready = 1;
        cycle();
        dm_req_ready = 0;
        cycle(); cycle();
        clear = 1;
        look(); chk("t6_clear_resp_ready", dm_resp_ready, 1'b0); finish();
        clear = 0; resp0_ready = 1;
        req1 = {7'h3C, 2'b01, 32'h0}; req1_valid = 1;
        look();
        chk("t6_owner_cleared", owner, 2'b00);
        chk("t6_no_resp0", resp0_valid, 1'b0);
        chk("t6_grant1", req1_ready, 1'b1);
        finish();
        req1_valid = 0; dm_req_ready = 1;
        cycle();
        dm_req_ready = 0; dm_resp_valid = 1; dm_resp = {32'h5555_0001, 2'b00};
        cycle();
        dm_resp_valid = 0; resp1_ready = 1;
        look(); chk("t6_resp1", resp1, {32'h5555_0001, 2'b00}); finish();
        idle_inputs();

        // Reset in ISSUE
        req0_valid = 1;
        cycle();
        req0_valid = 0; rst = 1;
        cycle();
        rst = 0;
        look();
        chk("t7_valid", dm_req_valid, 1'b0);
        chk("t7_owner", owner, 2'b00);
        chk("t7_dm_req", dm_req, 41'h0);
        finish();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int rpct;
            rpct = ((c / 500) % 2 == 1) ? 4 : 40;
            rst   = ($urandom_range(0, 299) == 0);
            clear = ($urandom_range(0, 149) == 0);
            r = {$urandom(), $urandom()}; req0 = r[40:0];
            r = {$urandom(), $urandom()}; req1 = r[40:0];
            r = {$urandom(), $urandom()}; dm_resp = r[33:0];
            req0_valid    = ($urandom_range(0, 99) < 50);
            req1_valid    = ($urandom_range(0, 99) < 50);
            resp0_ready   = ($urandom_range(0, 99) < 60);
            resp1_ready   = ($urandom_range(0, 99) < 60);
            dm_req_ready  = ($urandom_range(0, 99) < 50);
            dm_resp_valid = ($urandom_range(0, 99) < rpct);
            cycle();
        end

        idle_inputs();
        cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
- Shares the Debug Module's single DMI request/response port between two DMI masters: port 0 is the JTAG DTM, port 1 is a secondary debug transport.
- Allows one outstanding transaction at a time, with round-robin grant, and routes each response back to the requester that issued it.
- A response watchdog synthesises a DTM_ERR response if the DM never answers.
- Sits in the DM clock domain, after the DTM's CDC and before dm_top's DMI interface.

Parameters:
- TIMEOUT_CYCLES, default 1024: maximum number of cycles spent in WAIT_RESP before a synthetic error response; 0 disables the watchdog.
- CNT_W, default 11: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  DM clock; the single clock of the block.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  DMI clear (dmihardreset path); synchronous abort to IDLE.
- req0_i  in  dm::dmi_req_t (41)  port 0 request {addr[6:0], op[1:0], data[31:0]}.
- req0_valid_i  in  1  port 0 request valid.
- req0_ready_o  out  1  port 0 request accepted.
- resp0_o  out  dm::dmi_resp_t (34)  port 0 response {data[31:0], resp[1:0]}.
- resp0_valid_o  out  1  port 0 response valid.
- resp0_ready_i  in  1  port 0 response taken.
- req1_i, req1_valid_i, req1_ready_o, resp1_o, resp1_valid_o, resp1_ready_i: same as the port 0 signals, for port 1.
- dm_req_o  out  dm::dmi_req_t (41)  request to the DM.
- dm_req_valid_o  out  1  request valid to the DM.
- dm_req_ready_i  in  1  DM accepts the request.
- dm_resp_i  in  dm::dmi_resp_t (34)  response from the DM.
- dm_resp_valid_i  in  1  DM response valid.
- dm_resp_ready_o  out  1  arbiter accepts the DM response.
- owner_o  out  2  one-hot owner of the in-flight transaction; 00 when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- States: IDLE, ISSUE, WAIT_RESP, RETURN. Registers:
  - state_q
  - owner_q
  - last_q (last granted port)
  - req_q (latched request)
  - resp_q (latched response)
  - cnt_q (watchdog counter)
- Reset (rst_i=1 at a clk_i edge):
  - state=IDLE, owner_q=00, last_q=1 (so port 0 wins the first tie), req_q='0, resp_q='0, cnt_q=0.
  - All valid/ready outputs and timeout_o are 0; dm_req_o='0; resp0_o/resp1_o='0.
- IDLE:
  - Grant is combinational: reqN_ready_o=1 only for the winning port, in the same cycle as its valid.
  - If only one port is valid, that port wins. If both are valid, the port != last_q wins.
  - On grant: req_q<=reqN_i, owner_q<=onehot(N), last_q<=N, next state ISSUE.
  - The op field is forwarded unmodified; NOP is forwarded too.
- ISSUE:
  - dm_req_valid_o=1 and dm_req_o=req_q, held stable until dm_req_ready_i.
  - On dm_req_ready_i: cnt_q<=0, next state WAIT_RESP.
- WAIT_RESP:
  - dm_resp_ready_o=1.
  - On dm_resp_valid_i: resp_q<=dm_resp_i, next state RETURN. A response always takes priority over the watchdog in the same cycle.
  - Otherwise cnt_q increments. When TIMEOUT_CYCLES!=0 and cnt_q==TIMEOUT_CYCLES-1: resp_q<={data=32'hDEADBEEF, resp=DTM_ERR}, timeout_o=1 for one cycle, next state RETURN.
- RETURN:
  - respN_valid_o=1 for the owner only, with respN_o=resp_q held stable.
  - On respN_ready_i: owner_q<=00, next state IDLE.
  - Minimum request-to-response latency: grant cycle, plus 1 ISSUE cycle, plus 1 WAIT_RESP cycle, then the response is visible in the next cycle.
- dm_resp_ready_o is 0 outside WAIT_RESP. A late DM response after a timeout is back-pressured until the next transaction's WAIT_RESP. The DTM is required to issue dmihardreset (clear_i) after a DTM_ERR timeout, which clears this condition.
- reqN_ready_o is 0 in every state except IDLE; a requester holding valid simply waits.
- clear_i=1 (evaluated after rst_i, before all FSM logic):
  - state<=IDLE, owner_q<=00, cnt_q<=0, req_q/resp_q<='0. last_q is kept.
  - The in-flight transaction is dropped with no response to the requester.
  - No grant happens in a clear cycle; all ready/valid outputs are 0 in that cycle.
  - The DM receives the same clear and discards its in-flight state.
- The non-owner's respN_valid_o is always 0. owner_o equals owner_q.

Test Plan:
- Single port-0 read: req0 {addr=7'h11, op=READ}; DM ready immediately and returns {data=32'h0000_0A5A, resp=SUCCESS} after 3 cycles -> resp0 carries 32'h0A5A/SUCCESS; resp1_valid_o never asserts; owner_o=01 then 00.
- Simultaneous port 0 and port 1 valid, held for 4 back-to-back transactions -> grants in order 0,1,0,1; each response returns to its issuer with the data the DM returned for that address.
- DM holds dm_req_ready_i=0 for 5 cycles -> dm_req_valid_o stays 1 and dm_req_o stays unchanged; no new grant is made.
- TIMEOUT_CYCLES=8, DM never responds -> timeout_o pulses exactly 8 cycles after the DM accepts the request; owner receives {32'hDEADBEEF, DTM_ERR}.
- Response arrives in the same cycle the counter reaches 7 (TIMEOUT_CYCLES=8) -> real response delivered; timeout_o stays 0.
- clear_i asserted in WAIT_RESP -> IDLE the next cycle, no respN_valid_o; a subsequent port-1 request is granted normally. rst_i asserted mid-ISSUE -> all outputs 0 at the next edge.
